line_timing_decoder: RTL and testbench

Receive-side counterpart of the horizontal timing generator: samples `MCKR`, `HSYNC` and `HBLANK_b` in the `clk100` domain and reconstructs pixel position, line count and active-video state. Locks once the measured line length stays stable, and flags sync faults. Sits between the timing generator and downstream consumers such as the scan-converter and capture logic, which need a clean per-pixel strobe and position instead of raw sync levels.

---
 rtl/video_timing_pkg.sv | 13 +
 rtl/line_timing_decoder_if.sv | 30 +++
 rtl/rise_detect.sv | 24 ++
 rtl/line_timing_decoder.sv | 196 +++++++++++++++++++
 tb/tb_line_timing_decoder.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// Shared video timing types and widths for the line timing decoder slice.
package video_timing_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } ltd_state_t;

    localparam int HCNT_W = 9;
    localparam int VCNT_W = 9;

endpackage

// File: rtl/line_timing_decoder_if.sv
// Raw horizontal timing inputs plus the decoded pixel/line outputs.
// master = timing source / consumer side, slave = decoder side.
interface line_timing_decoder_if;
    import video_timing_pkg::*;

    logic              MCKR;
    logic              HSYNC;
    logic              HBLANK_b;
    logic              pix_tick;
    logic [HCNT_W-1:0] hpos;
    logic [VCNT_W-1:0] vline;
    logic              active;
    logic              line_start;
    logic [HCNT_W-1:0] line_len;
    logic              locked;
    logic              sync_err;
    logic [HCNT_W-1:0] active_len;

    modport master (
        output MCKR, HSYNC, HBLANK_b,
        input  pix_tick, hpos, vline, active, line_start,
               line_len, locked, sync_err, active_len
    );

    modport slave (
        input  MCKR, HSYNC, HBLANK_b,
        output pix_tick, hpos, vline, active, line_start,
               line_len, locked, sync_err, active_len
    );
endinterface

// File: rtl/rise_detect.sv
// Registered rising-edge detector: q samples d when en is high,
// rise is d high while the last sampled value was low.
module rise_detect (
    input  logic clk100,
    input  logic rst_b,
    input  logic en,
    input  logic d,
    output logic rise
);

    logic q_reg;

    // Keep the previous sampled level of d.
    always_ff @(posedge clk100 or negedge rst_b) begin
        if (!rst_b) begin
            q_reg <= 1'b0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign rise = d & ~q_reg;

endmodule

// File: rtl/line_timing_decoder.sv
// Horizontal line timing decoder: turns sampled MCKR/HSYNC/HBLANK_b levels
// into a pixel strobe, pixel/line position, line length and lock status.
// Optional feature macro: LINE_TIMING_ACTIVE_WIDTH_EN (active-width counter).
module line_timing_decoder
    import video_timing_pkg::*;
#(
    parameter int MAX_LEN    = 511,
    parameter int LOCK_LINES = 4
) (
    input  logic                 clk100,
    input  logic                 rst_b,
    line_timing_decoder_if.slave bus
);

    localparam int                MCNT_W     = $clog2(LOCK_LINES + 1);
    localparam logic [HCNT_W-1:0] HPOS_MAX   = HCNT_W'(MAX_LEN);
    localparam logic [HCNT_W-1:0] HPOS_LAST  = HCNT_W'(MAX_LEN - 1);
    localparam logic [MCNT_W-1:0] MATCH_LOCK = MCNT_W'(LOCK_LINES);

    ltd_state_t        state_reg, state_next;
    logic              tick, hs_rise, sync_rise;
    logic [HCNT_W-1:0] hpos_reg, line_len_reg, len_new;
    logic [VCNT_W-1:0] vline_reg;
    logic [MCNT_W-1:0] match_cnt_reg, match_cnt_next, cnt_up;
    logic              pix_tick_reg, line_start_reg, sync_err_reg, active_reg;
    logic              len_match, at_limit, measure_en, err_next;

    rise_detect u_mckr_rise (
        .clk100 (clk100),
        .rst_b  (rst_b),
        .en     (1'b1),
        .d      (bus.MCKR),
        .rise   (tick)
    );

    // HSYNC is only sampled on pixel ticks, so its edge is in pixel time.
    rise_detect u_hsync_rise (
        .clk100 (clk100),
        .rst_b  (rst_b),
        .en     (tick),
        .d      (bus.HSYNC),
        .rise   (hs_rise)
    );

    assign sync_rise = tick & hs_rise;
    assign len_new   = hpos_reg + HCNT_W'(1);
    assign len_match = (len_new == line_len_reg);
    // The next tick would land on MAX_LEN: that tick is the timeout.
    assign at_limit  = (hpos_reg >= HPOS_LAST);
    assign cnt_up    = len_match ? (match_cnt_reg + MCNT_W'(1)) : MCNT_W'(1);

    // FSM state register.
    always_ff @(posedge clk100 or negedge rst_b) begin
        if (!rst_b) begin
            state_reg <= SEARCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state: a sync rise always beats a simultaneous timeout.
    always_comb begin
        state_next = state_reg;
        if (tick) begin
            case (state_reg)
                SEARCH: begin
                    if (hs_rise) state_next = MEASURE;
                end
                MEASURE: begin
                    if (hs_rise) begin
                        if (cnt_up == MATCH_LOCK) state_next = LOCKED;
                    end else if (at_limit) begin
                        state_next = SEARCH;
                    end
                end
                LOCKED: begin
                    if (hs_rise) begin
                        if (!len_match) state_next = MEASURE;
                    end else if (at_limit) begin
                        state_next = SEARCH;
                    end
                end
                default: state_next = SEARCH;
            endcase
        end
    end

    // FSM outputs: measurement strobe, fault strobe and match counter update.
    always_comb begin
        measure_en     = 1'b0;
        err_next       = 1'b0;
        match_cnt_next = match_cnt_reg;
        if (tick) begin
            case (state_reg)
                MEASURE: begin
                    if (hs_rise) begin
                        measure_en     = 1'b1;
                        match_cnt_next = cnt_up;
                    end else if (at_limit) begin
                        err_next       = 1'b1;
                        match_cnt_next = '0;
                    end
                end
                LOCKED: begin
                    if (hs_rise) begin
                        measure_en = 1'b1;
                        if (!len_match) begin
                            err_next       = 1'b1;
                            match_cnt_next = MCNT_W'(1);
                        end
                    end else if (at_limit) begin
                        err_next       = 1'b1;
                        match_cnt_next = '0;
                    end
                end
                default: begin
                    measure_en = 1'b0;
                end
            endcase
        end
    end

    // Single-cycle strobes, re-evaluated every clk100 cycle.
    always_ff @(posedge clk100 or negedge rst_b) begin
        if (!rst_b) begin
            pix_tick_reg   <= 1'b0;
            line_start_reg <= 1'b0;
            sync_err_reg   <= 1'b0;
        end else begin
            pix_tick_reg   <= tick;
            line_start_reg <= sync_rise;
            sync_err_reg   <= err_next;
        end
    end

    // Pixel position and active flag; hpos saturates at MAX_LEN.
    always_ff @(posedge clk100 or negedge rst_b) begin
        if (!rst_b) begin
            hpos_reg   <= '0;
            active_reg <= 1'b0;
        end else if (tick) begin
            active_reg <= bus.HBLANK_b;
            if (hs_rise) begin
                hpos_reg <= '0;
            end else if (hpos_reg != HPOS_MAX) begin
                hpos_reg <= hpos_reg + HCNT_W'(1);
            end
        end
    end

    // Line measurement: length, line count and consecutive-match count.
    always_ff @(posedge clk100 or negedge rst_b) begin
        if (!rst_b) begin
            line_len_reg  <= '0;
            vline_reg     <= '0;
            match_cnt_reg <= '0;
        end else begin
            match_cnt_reg <= match_cnt_next;
            if (measure_en) begin
                line_len_reg <= len_new;
                vline_reg    <= vline_reg + VCNT_W'(1);
            end
        end
    end

`ifdef LINE_TIMING_ACTIVE_WIDTH_EN
    logic [HCNT_W-1:0] act_cnt_reg, active_len_reg;

    // Count HBLANK_b-high ticks per line; publish and clear on each sync rise.
    always_ff @(posedge clk100 or negedge rst_b) begin
        if (!rst_b) begin
            act_cnt_reg    <= '0;
            active_len_reg <= '0;
        end else if (sync_rise) begin
            active_len_reg <= act_cnt_reg;
            act_cnt_reg    <= '0;
        end else if (tick && bus.HBLANK_b && (act_cnt_reg != '1)) begin
            act_cnt_reg <= act_cnt_reg + HCNT_W'(1);
        end
    end

    assign bus.active_len = active_len_reg;
`else
    assign bus.active_len = '0;
`endif

    assign bus.pix_tick   = pix_tick_reg;
    assign bus.hpos       = hpos_reg;
    assign bus.vline      = vline_reg;
    assign bus.active     = active_reg;
    assign bus.line_start = line_start_reg;
    assign bus.line_len   = line_len_reg;
    assign bus.locked     = (state_reg == LOCKED);
    assign bus.sync_err   = sync_err_reg;

endmodule

// File: tb/tb_line_timing_decoder.sv
// Directed testbench for line_timing_decoder: lock, length fault, timeout,
// mid-line reset, active width and vline wrap.
module tb_line_timing_decoder;
    import video_timing_pkg::*;

`ifdef LINE_TIMING_ACTIVE_WIDTH_EN
    localparam int ACT_EXP = 336;
`else
    localparam int ACT_EXP = 0;
`endif

    logic clk100 = 1'b0;
    logic rst_b  = 1'b0;

    line_timing_decoder_if bus();

    line_timing_decoder dut (
        .clk100 (clk100),
        .rst_b  (rst_b),
        .bus    (bus)
    );

    always #5 clk100 = ~clk100;

    int n_cmp     = 0;
    int n_bad     = 0;
    int half      = 7;
    int seq_bad   = 0;
    int wide_bad  = 0;
    int err_total = 0;
    int err_base  = 0;
    int to_bad    = 0;
    int err_k     = 0;
    int err_h     = 0;

    logic       s_tick, s_ls, s_err, s_locked, s_active;
    logic [8:0] s_hpos, s_len, s_vline, s_alen;
    logic       r_locked;
    logic [8:0] r_len, r_vline, r_alen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %-16s got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %-16s got %0d", tag, got);
        end
    endtask

    // One MCKR period; outputs are snapshotted the cycle after the tick.
    task automatic px(input logic hs, input logic hb);
        bus.MCKR     = 1'b1;
        bus.HSYNC    = hs;
        bus.HBLANK_b = hb;
        @(negedge clk100);
        s_tick   = bus.pix_tick;
        s_ls     = bus.line_start;
        s_err    = bus.sync_err;
        s_locked = bus.locked;
        s_active = bus.active;
        s_hpos   = bus.hpos;
        s_len    = bus.line_len;
        s_vline  = bus.vline;
        s_alen   = bus.active_len;
        if (s_err === 1'b1) err_total++;
        if (half == 1) bus.MCKR = 1'b0;
        @(negedge clk100);
        if (bus.pix_tick !== 1'b0 || bus.line_start !== 1'b0 || bus.sync_err !== 1'b0)
            wide_bad++;
        if (half > 1) begin
            repeat (half - 2) @(negedge clk100);
            bus.MCKR = 1'b0;
            repeat (half) @(negedge clk100);
        end
    endtask

    // One line (or its first len ticks): HSYNC on ticks 0..hsw-1,
    // HBLANK_b high on ticks 64..399 when act is set.
    task automatic run_line(input int len, input int hsw, input bit act);
        logic hb;
        for (int t = 0; t < len; t++) begin
            hb = act && (t >= 64) && (t < 400);
            px(t < hsw, hb);
            if (s_hpos !== HCNT_W'(t) || s_ls !== (t == 0) || s_tick !== 1'b1 || s_active !== hb)
                seq_bad++;
            if (t == 0) begin
                r_locked = s_locked;
                r_len    = s_len;
                r_vline  = s_vline;
                r_alen   = s_alen;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.MCKR     = 1'b0;
        bus.HSYNC    = 1'b0;
        bus.HBLANK_b = 1'b0;
        repeat (3) @(negedge clk100);
        chk("rst_pix_tick", bus.pix_tick, 0);
        chk("rst_hpos", bus.hpos, 0);
        chk("rst_vline", bus.vline, 0);
        chk("rst_line_len", bus.line_len, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_sync_err", bus.sync_err, 0);
        chk("rst_active_len", bus.active_len, 0);
        rst_b = 1'b1;
        @(negedge clk100);

        // Generator pacing: MCKR period 14 clk100 cycles, 456-tick lines.
        half = 7;
        run_line(456, 32, 1);
        chk("r0_line_len", r_len, 0);
        chk("r0_vline", r_vline, 0);
        run_line(456, 32, 1);
        run_line(456, 32, 1);
        run_line(456, 32, 1);
        chk("r3_locked", r_locked, 0);

        // Faster MCKR for the remaining scenarios.
        half = 1;
        run_line(456, 32, 1);
        chk("r4_locked", r_locked, 1);
        chk("r4_line_len", r_len, 456);
        chk("r4_vline", r_vline, 4);
        chk("hpos_seq_a", seq_bad, 0);

        run_line(450, 32, 1);
        chk("r5_locked", r_locked, 1);
        run_line(456, 32, 1);
        chk("r6_err_count", err_total, 1);
        chk("r6_locked", r_locked, 0);
        chk("r6_line_len", r_len, 450);
        run_line(456, 32, 1);
        run_line(456, 32, 1);
        run_line(456, 32, 1);
        chk("r9_locked", r_locked, 0);
        run_line(456, 32, 1);
        chk("r10_locked", r_locked, 1);
        chk("r10_line_len", r_len, 456);
        chk("r10_active_len", r_alen, ACT_EXP);
        chk("r10_err_count", err_total, 1);

        // HSYNC held low from hpos 455: timeout when hpos reaches 511.
        for (int k = 1; k <= 80; k++) begin
            px(1'b0, 1'b0);
            if (s_hpos !== HCNT_W'((455 + k > 511) ? 511 : 455 + k)) to_bad++;
            if (s_err === 1'b1) begin
                err_k = k;
                err_h = int'(s_hpos);
            end
        end
        chk("to_hpos_track", to_bad, 0);
        chk("to_err_tick", err_k, 56);
        chk("to_err_hpos", err_h, 511);
        chk("to_err_count", err_total, 2);
        chk("to_locked", bus.locked, 0);
        chk("to_state", dut.state_reg, SEARCH);
        chk("to_hpos_hold", bus.hpos, 511);

        // Reacquire from SEARCH: the first rise does not count a line.
        run_line(456, 32, 1);
        chk("r11_vline", r_vline, 10);
        run_line(456, 32, 1);
        run_line(456, 32, 1);
        run_line(456, 32, 1);
        run_line(201, 32, 1);
        chk("r15_locked", r_locked, 1);
        chk("r15_vline", r_vline, 14);
        chk("pre_rst_hpos", bus.hpos, 200);

        // Asynchronous reset mid-line.
        rst_b = 1'b0;
        #1;
        chk("mid_rst_hpos", bus.hpos, 0);
        chk("mid_rst_vline", bus.vline, 0);
        chk("mid_rst_line_len", bus.line_len, 0);
        chk("mid_rst_locked", bus.locked, 0);
        chk("mid_rst_active", bus.active, 0);
        chk("mid_rst_act_len", bus.active_len, 0);
        repeat (3) @(negedge clk100);
        rst_b = 1'b1;
        @(negedge clk100);

        for (int k = 0; k < 100; k++) px(1'b0, 1'b0);
        chk("partial_len", bus.line_len, 0);
        run_line(8, 2, 0);
        chk("d0_line_len", r_len, 0);
        chk("d0_locked", r_locked, 0);
        run_line(8, 2, 0);
        chk("d1_line_len", r_len, 8);
        run_line(8, 2, 0);
        run_line(8, 2, 0);
        run_line(8, 2, 0);
        chk("d4_locked", r_locked, 1);
        chk("d4_vline", r_vline, 4);

        // 512 more locked lines: vline wraps back to its starting value.
        err_base = err_total;
        for (int n = 0; n < 512; n++) run_line(8, 2, 0);
        chk("wrap_vline", r_vline, 4);
        chk("wrap_locked", r_locked, 1);
        chk("wrap_errors", err_total - err_base, 0);
        chk("wrap_active_len", r_alen, 0);
        chk("hpos_seq_all", seq_bad, 0);
        chk("pulse_width", wide_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
